// File: rtl/lwe_pkg.sv
// Shared constants, FSM state type and LFSR step function for the LWE sampler.
package lwe_pkg;

  localparam int LWE_Q_W = 12;
  localparam int LWE_Q   = 3329;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    STALL = 2'd2
  } rng_state_t;

  // One Galois shift: feedback taps are folded in when the bit shifted out is set.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/lwe_sample_fifo.sv
// Synchronous FIFO with flush; head is zero while empty. Push is dropped when full,
// pop is ignored when empty; one-edge write-to-read latency.
module lwe_sample_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_push, do_pop;

  assign cnt      = wr_q - rd_q;
  assign full     = (cnt == FULL_CNT);
  assign empty    = (wr_q == rd_q);
  assign head_dat = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q[AW-1:0]] = push_dat;
        wr_d = wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/lwe_rng_sampler.sv
// Rejection-sampled uniform RNG mod Q, FIFO-buffered; sample valid one edge after generation,
// LFSR frozen while the FIFO is full. LWE_RNG_STATS_EN adds a saturating reject counter.
module lwe_rng_sampler
  import lwe_pkg::*;
#(
  parameter int LFSR_W = 32,
  parameter int Q_W    = LWE_Q_W,
  parameter int Q      = LWE_Q,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rng_on,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [Q_W-1:0]    sample,
  output logic              busy,
  output logic              seed_err
`ifdef LWE_RNG_STATS_EN
  ,
  output logic [15:0]       reject_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);
  localparam logic [Q_W:0]  Q_LIM     = (Q_W+1)'(Q);

  rng_state_t        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic              seed_err_q, seed_err_d;
  logic [Q_W-1:0]    cand;
  logic              accept, advance, push, pop, flush;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_cnt;

  assign lfsr_nxt     = lfsr_step(lfsr_q);
  assign cand         = lfsr_nxt[Q_W-1:0];
  assign accept       = ({1'b0, cand} < Q_LIM);
  assign sample_valid = ~fifo_empty;
  assign pop          = sample_valid & sample_ready;
  assign busy         = (state_q != IDLE);
  assign seed_err     = seed_err_q;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seed_err_d = seed_err_q;
    advance    = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_d     = (seed == '0) ? LFSR_W'(1) : seed;
          seed_err_d = (seed == '0);
        end
        if (rng_on) state_d = GEN;
      end
      GEN: begin
        if (!rng_on) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (!fifo_full) begin
          advance = 1'b1;
          push    = accept;
          // Registered count plus a pop the same edge means this push cannot fill.
          if (accept && fifo_cnt == LAST_SLOT && !pop) state_d = STALL;
        end else begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (!rng_on) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (!fifo_full) begin
          state_d = GEN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (advance) lfsr_d = lfsr_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_W'(1);
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_err_q <= seed_err_d;
    end
  end

`ifdef LWE_RNG_STATS_EN
  logic [15:0] rej_cnt_q, rej_cnt_d;

  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (state_q == IDLE && seed_load) begin
      rej_cnt_d = '0;
    end else if (advance && !accept && rej_cnt_q != 16'hFFFF) begin
      rej_cnt_d = rej_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rej_cnt_q <= '0;
    else     rej_cnt_q <= rej_cnt_d;
  end

  assign reject_cnt = rej_cnt_q;
`endif

  lwe_sample_fifo #(
    .W     (Q_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (cand),
    .pop      (pop),
    .flush    (flush),
    .head_dat (sample),
    .cnt      (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_lwe_rng_sampler.sv
// Randomized and directed bench for lwe_rng_sampler against a stream-level reference model.
module tb_lwe_rng_sampler;
  import lwe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rng_on, seed_load, sample_ready;
  logic [31:0] seed;
  logic        sample_valid, busy, seed_err;
  logic [11:0] sample;
`ifdef LWE_RNG_STATS_EN
  logic [15:0] reject_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [31:0] m_lfsr;
  logic        hold_vld;
  logic [11:0] hold_dat;

  always #5 clk = ~clk;

  lwe_rng_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .rng_on       (rng_on),
    .seed_load    (seed_load),
    .seed         (seed),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample       (sample),
    .busy         (busy),
`ifdef LWE_RNG_STATS_EN
    .seed_err     (seed_err),
    .reject_cnt   (reject_cnt)
`else
    .seed_err     (seed_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Next accepted value of the ideal sample stream; rejected values never appear.
  task automatic model_next(output logic [11:0] v);
    v = '0;
    for (int i = 0; i < 1000; i++) begin
      m_lfsr = step(m_lfsr);
      if ((m_lfsr % 4096) < 3329) begin
        v = m_lfsr[11:0];
        return;
      end
    end
  endtask

  function automatic logic [31:0] lfsr_after(input logic [31:0] s, input int n);
    int got = 0;
    for (int i = 0; i < 10000 && got < n; i++) begin
      s = step(s);
      if ((s % 4096) < 3329) got++;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rng_on = 1'b0; seed_load = 1'b0; sample_ready = 1'b0; seed = '0;
    tick();
    rst = 1'b0;
    m_lfsr = 32'h1;
    hold_vld = 1'b0;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed = s; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      sample_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (hold_vld) begin
        check_eq("hold_vld", 32'(sample_valid), 32'd1);
        check_eq("hold_dat", 32'(sample), 32'(hold_dat));
      end
      if (sample_valid && sample_ready) begin
        model_next(e);
        check_eq("pop", 32'(sample), 32'(e));
        pops++;
      end
      hold_vld = sample_valid && !sample_ready;
      hold_dat = sample;
      tick();
    end
    hold_vld = 1'b0;
  endtask

  task automatic wait_stall(input string tag);
    int n = 0;
    while (dut.state_q != STALL && n < 30) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(dut.state_q), 32'(STALL));
  endtask

  initial begin
    logic [11:0] e;
    int exp4 [4] = '{3, 2, 1, 3};
    int p0;
    int n;

    // Reset values
    do_reset();
    check_eq("rst_vld", 32'(sample_valid), 0);
    check_eq("rst_sample", 32'(sample), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_seed_err", 32'(seed_err), 0);
    check_eq("rst_lfsr", dut.lfsr_q, 32'h1);

    // Default seed: first sample two edges after rng_on, then 3,2,1,3
    rng_on = 1'b1; sample_ready = 1'b1;
    tick();
    check_eq("first_early", 32'(sample_valid), 0);
    check_eq("first_busy", 32'(busy), 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      check_eq("seq_vld", 32'(sample_valid), 1);
      check_eq("seq_val", 32'(sample), 32'(exp4[k]));
      tick();
    end
    rng_on = 1'b0;
    tick();
    check_eq("off_vld", 32'(sample_valid), 0);
    check_eq("off_busy", 32'(busy), 0);

    // Rejected candidate never reaches the FIFO
    do_reset();
    load_seed(32'h0000_1FFE);
    check_eq("seed_lfsr", dut.lfsr_q, 32'h0000_1FFE);
    rng_on = 1'b1; sample_ready = 1'b0;
    tick();
    tick();
    check_eq("rej_vld", 32'(sample_valid), 0);
    check_eq("rej_lfsr", dut.lfsr_q, 32'h0000_0FFF);
    rng_on = 1'b0;
    tick();
    load_seed(32'h0000_0FFE);
    rng_on = 1'b1;
    tick();
    tick();
    check_eq("acc_vld", 32'(sample_valid), 1);
    check_eq("acc_val", 32'(sample), 32'd2047);
    rng_on = 1'b0;
    tick();

    // Backpressure: fill, freeze, then drain without gaps or repeats
    do_reset();
    rng_on = 1'b1; sample_ready = 1'b0;
    wait_stall("stall_state");
    check_eq("stall_cnt", 32'(dut.fifo_cnt), 4);
    check_eq("stall_lfsr", dut.lfsr_q, lfsr_after(32'h1, 4));
    tick(); tick(); tick();
    check_eq("stall_frozen", dut.lfsr_q, lfsr_after(32'h1, 4));
    pops = 0;
    run_cycles(20, 1'b0);
    check_eq("drain_pops_ge", 32'(pops >= 12), 1);

    // Zero seed is replaced and flagged; a nonzero seed clears the flag
    do_reset();
    load_seed(32'h0);
    check_eq("zseed_err", 32'(seed_err), 1);
    check_eq("zseed_lfsr", dut.lfsr_q, 32'h1);
    load_seed(32'h5);
    check_eq("nzseed_err", 32'(seed_err), 0);
    check_eq("nzseed_lfsr", dut.lfsr_q, 32'h5);

    // Drop rng_on with three queued: flush, retain LFSR, resume after the flushed values
    do_reset();
    rng_on = 1'b1; sample_ready = 1'b0;
    wait_stall("drop_stall");
    sample_ready = 1'b1;
    model_next(e);
    check_eq("drop_head", 32'(sample), 32'(e));
    tick();
    sample_ready = 1'b0;
    check_eq("drop_cnt3", 32'(dut.fifo_cnt), 3);
    rng_on = 1'b0;
    tick();
    check_eq("drop_vld", 32'(sample_valid), 0);
    check_eq("drop_busy", 32'(busy), 0);
    check_eq("drop_lfsr", dut.lfsr_q, lfsr_after(32'h1, 4));
    for (int k = 0; k < 3; k++) model_next(e);
    rng_on = 1'b1;
    pops = 0;
    run_cycles(12, 1'b0);
    check_eq("resume_pops_ge", 32'(pops >= 4), 1);

    // Reset during a stalled handshake
    sample_ready = 1'b0;
    n = 0;
    while (!sample_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq("pre_rst_vld", 32'(sample_valid), 1);
    rst = 1'b1; rng_on = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_vld", 32'(sample_valid), 0);
    check_eq("mid_rst_sample", 32'(sample), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_err", 32'(seed_err), 0);
    check_eq("mid_rst_lfsr", dut.lfsr_q, 32'h1);

    // Random seeds and random backpressure against the stream model
    for (int it = 0; it < 8; it++) begin
      logic [31:0] s;
      do_reset();
      s = $urandom;
      if (s == 0) s = 32'h1;
      load_seed(s);
      m_lfsr = s;
      rng_on = 1'b1;
      p0 = pops;
      run_cycles(80, 1'b1);
      check_eq("rnd_progress", 32'(pops > p0), 1);
      rng_on = 1'b0;
      tick();
      check_eq("rnd_off_vld", 32'(sample_valid), 0);
      check_eq("rnd_off_busy", 32'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lwe_rng_sampler.md
Name: lwe_rng_sampler

Overview:
- Uniform sampler that produces integers in [0, Q) for key generation and encryption.
- Sits directly downstream of the mode controller and is gated by its rng_on enable.
- A 32-bit Galois LFSR is rejection-sampled mod Q. Accepted samples are buffered in a small FIFO.
- Consumers pull samples over a valid/ready handshake.

Parameters:
- LFSR_W, 32, LFSR state width (fixed polynomial below; only 32 supported).
- Q_W, 12, sample width in bits.
- Q, 3329, modulus; must satisfy Q <= 2**Q_W.
- DEPTH, 4, sample FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rng_on  in  1  enable from the mode controller.
- seed_load  in  1  load seed; honoured only in IDLE.
- seed  in  32  seed value.
- sample_valid  out  1  FIFO head valid.
- sample_ready  in  1  consumer accepts head.
- sample  out  Q_W  FIFO head value.
- busy  out  1  high in GEN or STALL.
- seed_err  out  1  sticky flag: a zero seed was loaded.

Behaviour:
- Reset values:
  - lfsr = 32'h0000_0001, state = IDLE, FIFO empty.
  - sample_valid = 0, sample = 0, busy = 0, seed_err = 0.
- LFSR step (Galois, TAPS = 32'h8020_0003):
  - next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
  - candidate = next[Q_W-1:0].
  - Accept iff candidate < Q; rejected candidates are discarded.
- FSM states:
  - IDLE -> GEN: on the edge where rng_on = 1.
  - GEN: advances the LFSR every edge while count < DEPTH, pushing the candidate if accepted.
    - GEN -> STALL when the push fills the FIFO.
    - GEN -> IDLE when rng_on = 0.
  - STALL: LFSR frozen.
    - STALL -> GEN when count < DEPTH.
    - STALL -> IDLE when rng_on = 0.
- Latency: an accepted candidate is visible as sample_valid/sample on the edge after it is generated. The first sample appears 2 edges after rng_on is first sampled high.
- Determinism: the LFSR only advances when a push is possible, so the emitted sequence is independent of consumer backpressure.
- Full FIFO with simultaneous pop: count is evaluated from registered state, so no push occurs that cycle and the pop still occurs.
- Handshake:
  - Pop on sample_valid & sample_ready.
  - sample holds stable while valid & !ready.
  - sample_ready while empty is ignored.
- Seed loading:
  - seed_load in IDLE loads the seed.
  - seed == 0 loads 32'h1 instead and sets seed_err.
  - seed_err clears on the next nonzero seed_load.
  - seed_load outside IDLE is ignored.
- rng_on falling (sampled 0 in GEN/STALL):
  - Go to IDLE and flush the FIFO the same edge, so sample_valid = 0 next cycle.
  - LFSR state is retained, not reseeded.
- busy = (state != IDLE).
- rst at any point restores all reset values on that edge, including mid-handshake.

Optional Feature:
- Macro: LWE_RNG_STATS_EN.
- Defined: adds output reject_cnt[15:0].
  - Counts rejected candidates and saturates at 16'hFFFF.
  - Cleared by rst and by seed_load.
- Undefined: port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package lwe_pkg holds:
  - LWE_Q, LWE_Q_W, LFSR_TAPS constants.
  - rng_state_t enum {IDLE, GEN, STALL}.
- One sub-module: lwe_sample_fifo.
  - Parametrised synchronous FIFO with push, pop, flush, count, full and empty.
  - Instantiated once.

Test Plan:
- Reset, then rng_on = 1 with the default seed and sample_ready = 1 -> samples 3, 2, 1, 3 in order; first sample_valid 2 edges after rng_on.
- Load seed 32'h0000_1FFE, rng_on = 1 -> candidate 4095 is rejected with no push; load seed 32'h0000_0FFE instead -> first sample 2047.
- sample_ready = 0 with rng_on = 1 -> FIFO fills to 4 entries, state STALL, LFSR frozen. Release ready -> sequence continues without gaps or repeats (3, 2, 1, 3, ...).
- seed_load with seed = 0 -> seed_err = 1 and LFSR = 1. Then seed 32'h5 -> seed_err = 0.
- Drop rng_on with 3 entries queued -> next cycle sample_valid = 0 and busy = 0. Re-enable -> the sequence continues from the retained LFSR state.
- Assert rst while sample_valid & !sample_ready -> next cycle all outputs are at reset values and lfsr = 1.
